// File: rtl/i2c_target_pkg.sv
// rtl/i2c_target_pkg.sv - shared types and constants for the I2C register target
package i2c_target_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;

    localparam logic ACK_LVL  = 1'b0;
    localparam logic NACK_LVL = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RD_ACKCHK,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/i2c_target_filter.sv
// rtl/i2c_target_filter.sv - pin synchronizer, deglitch filter and edge pulses for one I2C line
module i2c_target_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic line,
    output logic rise,
    output logic fall
);

    logic [1:0] sync;
    logic [3:0] cnt;

    // Lines idle high, so reset to the released level to avoid a fake edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
            line <= 1'b1;
            cnt  <= 4'd0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], pad};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] != line) begin
                if (cnt == 4'(FILT_LEN - 1)) begin
                    line <= sync[1];
                    cnt  <= 4'd0;
                    rise <= sync[1];
                    fall <= ~sync[1];
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end else begin
                cnt <= 4'd0;
            end
        end
    end

endmodule

// File: rtl/i2c_target_regif.sv
// rtl/i2c_target_regif.sv - I2C target exposing an 8-bit register space through a single-cycle register port
module i2c_target_regif
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int          FILT_LEN   = 3,
    parameter int          HOLD_CYC   = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                scl_pad_i,
    input  logic                sda_pad_i,
    output logic                sda_pad_o,
    output logic                sda_padoen_o,
    output logic [BYTE_W-1:0]   reg_addr_o,
    output logic [BYTE_W-1:0]   reg_wdata_o,
    output logic                reg_we_o,
    output logic                reg_re_o,
    input  logic [BYTE_W-1:0]   reg_rdata_i,
    output logic                busy_o
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYC - 1);

    logic scl_line, scl_rise, scl_fall;
    logic sda_line, sda_rise, sda_fall;

    i2c_target_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk (wb_clk_i), .rst (wb_rst_i), .pad (scl_pad_i),
        .line(scl_line), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_target_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk (wb_clk_i), .rst (wb_rst_i), .pad (sda_pad_i),
        .line(sda_line), .rise(sda_rise), .fall(sda_fall)
    );

    state_t                 state;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [BYTE_W-2:0]      rx_sr;
    logic [BYTE_W-1:0]      tx_sr;
    logic [BYTE_W-1:0]      rx_byte;
    logic                   rw;
    logic                   re_q;
    logic                   hold_pend;
    logic [7:0]             hold_cnt;
    logic                   sda_next;
    logic                   start_det;
    logic                   stop_det;

    assign sda_pad_o = 1'b0;
    assign rx_byte   = {rx_sr, sda_line};
    assign start_det = sda_fall & scl_line;
    assign stop_det  = sda_rise & scl_line;

    // Level to place on SDA once the hold delay after an SCL fall expires.
    // Read data captured this very cycle is taken straight from the port.
    always_comb begin
        sda_next = NACK_LVL;
        case (state)
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: sda_next = ACK_LVL;
            ST_RDATA: sda_next = re_q ? reg_rdata_i[BYTE_W-1] : tx_sr[BYTE_W-1];
            default:  sda_next = NACK_LVL;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            rx_sr        <= '0;
            tx_sr        <= '0;
            rw           <= 1'b0;
            re_q         <= 1'b0;
            hold_pend    <= 1'b0;
            hold_cnt     <= 8'd0;
            sda_padoen_o <= 1'b1;
            reg_addr_o   <= '0;
            reg_wdata_o  <= '0;
            reg_we_o     <= 1'b0;
            reg_re_o     <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            reg_we_o <= 1'b0;
            reg_re_o <= 1'b0;
            re_q     <= reg_re_o;
            if (re_q)
                tx_sr <= reg_rdata_i;
            if (reg_we_o)
                reg_addr_o <= reg_addr_o + 8'd1;

            if (stop_det) begin
                state        <= ST_IDLE;
                busy_o       <= 1'b0;
                sda_padoen_o <= 1'b1;
                hold_pend    <= 1'b0;
            end else if (start_det) begin
                state        <= ST_ADDR;
                bit_cnt      <= '0;
                sda_padoen_o <= 1'b1;
                hold_pend    <= 1'b0;
            end else begin
                if (scl_fall) begin
                    hold_pend <= 1'b1;
                    hold_cnt  <= HOLD_LOAD;
                end else if (hold_pend) begin
                    hold_cnt <= hold_cnt - 8'd1;
                    if (hold_cnt == 8'd1) begin
                        hold_pend    <= 1'b0;
                        sda_padoen_o <= sda_next;
                    end
                end

                if (scl_rise) begin
                    case (state)
                        ST_ADDR, ST_PTR, ST_WDATA: begin
                            rx_sr   <= rx_byte[BYTE_W-2:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= '0;
                                case (state)
                                    ST_ADDR: begin
                                        if (rx_byte[7:1] == TARGET_ADDR) begin
                                            state  <= ST_ADDR_ACK;
                                            rw     <= rx_byte[0];
                                            busy_o <= 1'b1;
                                        end else begin
                                            state  <= ST_IGNORE;
                                            busy_o <= 1'b0;
                                        end
                                    end
                                    ST_PTR: begin
                                        reg_addr_o <= rx_byte;
                                        state      <= ST_PTR_ACK;
                                    end
                                    default: begin
                                        reg_wdata_o <= rx_byte;
                                        reg_we_o    <= 1'b1;
                                        state       <= ST_WDATA_ACK;
                                    end
                                endcase
                            end
                        end
                        // Non-zero count marks that the 9th clock has risen.
                        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: bit_cnt <= 3'd1;
                        ST_RDATA: begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= '0;
                                state   <= ST_RD_ACKCHK;
                            end
                        end
                        ST_RD_ACKCHK: begin
                            if (sda_line == ACK_LVL) begin
                                reg_addr_o <= reg_addr_o + 8'd1;
                                state      <= ST_RDATA;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                        default: ;
                    endcase
                end else if (scl_fall) begin
                    case (state)
                        ST_ADDR_ACK: begin
                            if (bit_cnt != '0) begin
                                bit_cnt <= '0;
                                if (rw) begin
                                    state    <= ST_RDATA;
                                    reg_re_o <= 1'b1;
                                end else begin
                                    state <= ST_PTR;
                                end
                            end
                        end
                        ST_PTR_ACK, ST_WDATA_ACK: begin
                            if (bit_cnt != '0) begin
                                bit_cnt <= '0;
                                state   <= ST_WDATA;
                            end
                        end
                        ST_RDATA: begin
                            if (bit_cnt == '0)
                                reg_re_o <= 1'b1;
                            else
                                tx_sr <= {tx_sr[BYTE_W-2:0], 1'b1};
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regif.sv
// tb/tb_i2c_target_regif.sv - self-checking bench for the I2C register target
module tb_i2c_target_regif;

    localparam int Q = 12;
    localparam int H = 24;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       sda_drv;
    logic       sda_pad_i;
    logic       sda_pad_o;
    logic       sda_padoen_o;
    logic [7:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       reg_we_o;
    logic       reg_re_o;
    logic [7:0] reg_rdata_i;
    logic       busy_o;

    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  model_ptr;
    logic [15:0] wq[$];
    logic [7:0]  rq[$];
    logic [15:0] we_log[$];
    logic [7:0]  rd_log[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          quiet_viol = 0;
    bit          quiet = 1'b0;
    bit          glitch_on = 1'b0;

    always #5 clk = ~clk;

    assign sda_pad_i   = sda_drv & (sda_padoen_o | sda_pad_o);
    assign reg_rdata_i = mem[reg_addr_o];

    i2c_target_regif #(.TARGET_ADDR(7'h50), .FILT_LEN(3), .HOLD_CYC(4)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .scl_pad_i   (scl),
        .sda_pad_i   (sda_pad_i),
        .sda_pad_o   (sda_pad_o),
        .sda_padoen_o(sda_padoen_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_we_o    (reg_we_o),
        .reg_re_o    (reg_re_o),
        .reg_rdata_i (reg_rdata_i),
        .busy_o      (busy_o)
    );

    function automatic logic [7:0] init_val(input logic [7:0] a);
        if (a == 8'h20) return 8'h33;
        if (a == 8'h21) return 8'h44;
        if (a == 8'h40) return 8'h12;
        return (a * 8'd73) ^ 8'h5C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register-port scoreboard plus the storage peripheral itself.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_val(8'(i));
        forever begin
            @(negedge clk);
            if (quiet && !sda_padoen_o) quiet_viol++;
            if (reg_we_o) begin
                n_checks++;
                if (wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_we: got addr %0h data %0h expected none", reg_addr_o, reg_wdata_o);
                end else begin
                    logic [15:0] e;
                    e = wq.pop_front();
                    n_checks--;
                    chk("we_addr_data", {16'd0, reg_addr_o, reg_wdata_o}, {16'd0, e});
                end
                we_log.push_back({reg_addr_o, reg_wdata_o});
                mem[reg_addr_o] = reg_wdata_o;
            end
            if (reg_re_o) begin
                n_checks++;
                if (rq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_re: got addr %0h expected none", reg_addr_o);
                end else begin
                    logic [7:0] e;
                    e = rq.pop_front();
                    n_checks--;
                    chk("re_addr", {24'd0, reg_addr_o}, {24'd0, e});
                end
            end
        end
    end

    task automatic wc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wc(Q);
        scl = 1'b1;     wc(H);
        sda_drv = 1'b0; wc(H);
        scl = 1'b0;     wc(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wc(Q);
        scl = 1'b1;     wc(H);
        sda_drv = 1'b1; wc(H);
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b; wc(Q);
        scl = 1'b1;
        if (glitch_on) begin
            wc(H / 2);
            sda_drv = ~b; wc(1);
            sda_drv = b;  wc(H - H / 2 - 1);
        end else begin
            wc(H);
        end
        scl = 1'b0; wc(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_drv = 1'b1; wc(Q);
        scl = 1'b1;     wc(H / 2);
        b = sda_pad_i;  wc(H - H / 2);
        scl = 1'b0;     wc(Q);
    endtask

    task automatic send_byte(input logic [7:0] v, input logic exp_ack);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        glitch_on = 1'b0;
        recv_bit(a);
        chk("ack", {31'd0, a}, {31'd0, exp_ack});
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] v);
        for (int i = 7; i >= 0; i--) recv_bit(v[i]);
        send_bit(ack);
    endtask

    task automatic wr_txn(input logic [7:0] ptr, input logic [7:0] d0, input logic [7:0] d1,
                          input int n, input bit glitch);
        i2c_start();
        send_byte(8'hA0, 1'b0);
        chk("busy_match", {31'd0, busy_o}, 32'd1);
        send_byte(ptr, 1'b0);
        model_ptr = ptr;
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            d = (i == 0) ? d0 : d1;
            wq.push_back({model_ptr, d});
            ref_mem[model_ptr] = d;
            model_ptr = model_ptr + 8'd1;
            glitch_on = glitch && (i == 0);
            send_byte(d, 1'b0);
        end
        i2c_stop();
        chk("busy_stop", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic rd_txn(input bit with_ptr, input logic [7:0] ptr, input int n);
        logic [7:0] d;
        if (with_ptr) begin
            i2c_start();
            send_byte(8'hA0, 1'b0);
            send_byte(ptr, 1'b0);
            model_ptr = ptr;
        end
        for (int i = 0; i < n; i++) rq.push_back(model_ptr + 8'(i));
        i2c_start();
        send_byte(8'hA1, 1'b0);
        chk("busy_rd", {31'd0, busy_o}, 32'd1);
        for (int i = 0; i < n; i++) begin
            read_byte((i == n - 1), d);
            chk("rdata", {24'd0, d}, {24'd0, ref_mem[model_ptr]});
            rd_log.push_back(d);
            if (i != n - 1) model_ptr = model_ptr + 8'd1;
        end
        wc(4);
        chk("sda_rel_nack", {31'd0, sda_padoen_o}, 32'd1);
        i2c_stop();
        chk("busy_stop", {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        logic b;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        model_ptr = 8'd0;
        rst = 1'b1; scl = 1'b1; sda_drv = 1'b1;
        wc(3);
        rst = 1'b0;
        wc(1);
        chk("rst_oe",    {31'd0, sda_padoen_o}, 32'd1);
        chk("rst_pad_o", {31'd0, sda_pad_o},    32'd0);
        chk("rst_addr",  {24'd0, reg_addr_o},   32'd0);
        chk("rst_wdata", {24'd0, reg_wdata_o},  32'd0);
        chk("rst_we_re", {30'd0, reg_we_o, reg_re_o}, 32'd0);
        chk("rst_busy",  {31'd0, busy_o},       32'd0);
        wc(10);

        we_log.delete();
        wr_txn(8'h10, 8'h5A, 8'hC3, 2, 1'b0);
        chk("wr_log_n", we_log.size(), 2);
        if (we_log.size() >= 2) begin
            chk("wr_first",  {16'd0, we_log[0]}, 32'h105A);
            chk("wr_second", {16'd0, we_log[1]}, 32'h11C3);
        end

        rd_log.delete();
        rd_txn(1'b1, 8'h20, 2);
        chk("rd_log_n", rd_log.size(), 2);
        if (rd_log.size() >= 2) begin
            chk("rd_first",  {24'd0, rd_log[0]}, 32'h33);
            chk("rd_second", {24'd0, rd_log[1]}, 32'h44);
        end

        quiet = 1'b1; quiet_viol = 0;
        i2c_start();
        send_byte(8'hB0, 1'b1);
        chk("busy_wrong", {31'd0, busy_o}, 32'd0);
        send_byte(8'h01, 1'b1);
        i2c_stop();
        quiet = 1'b0;
        chk("wrong_quiet", quiet_viol, 0);

        we_log.delete();
        wr_txn(8'hFF, 8'h01, 8'h02, 2, 1'b0);
        if (we_log.size() >= 2) begin
            chk("wrap_first",  {16'd0, we_log[0]}, 32'hFF01);
            chk("wrap_second", {16'd0, we_log[1]}, 32'h0002);
        end else begin
            chk("wrap_log_n", we_log.size(), 2);
        end

        wr_txn(8'h30, 8'h81, 8'h7E, 2, 1'b1);

        i2c_start();
        send_byte(8'hA0, 1'b0);
        send_byte(8'h40, 1'b0);
        rq.push_back(8'h40);
        i2c_start();
        send_byte(8'hA1, 1'b0);
        sda_drv = 1'b1; wc(Q);
        scl = 1'b1;     wc(H / 2);
        chk("rd_bit_low", {31'd0, sda_padoen_o}, 32'd0);
        rst = 1'b1;
        wc(1);
        chk("rst_mid_oe",   {31'd0, sda_padoen_o}, 32'd1);
        chk("rst_mid_addr", {24'd0, reg_addr_o},   32'd0);
        chk("rst_mid_busy", {31'd0, busy_o},       32'd0);
        rst = 1'b0;
        model_ptr = 8'd0;
        wc(H - H / 2);
        scl = 1'b0; wc(Q);
        i2c_stop();

        for (int it = 0; it < 8; it++) begin
            int kind;
            kind = $urandom_range(0, 2);
            if (kind == 0)
                wr_txn(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(1, 2), 1'b0);
            else if (kind == 1)
                rd_txn(1'b1, 8'($urandom), $urandom_range(1, 3));
            else
                rd_txn(1'b0, 8'd0, $urandom_range(1, 3));
        end

        wc(20);
        chk("wq_empty", wq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        b = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
